// File: rtl/lutram_fifo_pkg.sv
// ---------------------------------------------------------------------------
// lutram_fifo_pkg
// Shared definitions for the LUT-RAM FIFO slice.
//   fifo_op_e      : accepted-operation classification used for COUNT update
//   clog2          : ceiling log2 helper
//   depth_of       : entry count from a log2 depth
//   LUTRAM_FIFO_CHECK_PARAMS(W, DL2, AL) : elaboration-time range check,
//                    expanded inside a module body as generate items
// No ports (package).
// ---------------------------------------------------------------------------

`ifndef LUTRAM_FIFO_CHECK_PARAMS
`define LUTRAM_FIFO_CHECK_PARAMS(W, DL2, AL) \
    if ((W) < 1 || (W) > lutram_fifo_pkg::MAX_WIDTH) begin : g_check_width \
        $error("lutram_fifo: WIDTH %0d outside 1..%0d", (W), lutram_fifo_pkg::MAX_WIDTH); \
    end \
    if ((DL2) < 1 || (DL2) > lutram_fifo_pkg::MAX_DEPTH_LOG2) begin : g_check_depth \
        $error("lutram_fifo: DEPTH_LOG2 %0d outside 1..%0d", (DL2), lutram_fifo_pkg::MAX_DEPTH_LOG2); \
    end \
    if ((AL) < 1 || (AL) > lutram_fifo_pkg::depth_of(DL2)) begin : g_check_afull \
        $error("lutram_fifo: AFULL_LVL %0d outside 1..depth", (AL)); \
    end
`endif

package lutram_fifo_pkg;

    localparam int MAX_WIDTH      = 64;
    localparam int MAX_DEPTH_LOG2 = 8;

    // Encoded as {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int depth_of(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/lutram_sdp.sv
// ---------------------------------------------------------------------------
// lutram_sdp
// Generic WIDTH x 2**DEPTH_LOG2 semi-dual-port LUT RAM: synchronous write,
// asynchronous read. Parametrised generalisation of the 16x2 primitive.
//   CLK  in   clock, write on rising edge
//   WRE  in   write enable
//   WAD  in   write address
//   DI   in   write data
//   RAD  in   read address
//   DO   out  read data (combinational from RAD)
// ---------------------------------------------------------------------------
module lutram_sdp
    import lutram_fifo_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int DEPTH_LOG2 = 4,
    parameter logic [WIDTH*(2**DEPTH_LOG2)-1:0] INIT = '0
) (
    input  logic                  CLK,
    input  logic                  WRE,
    input  logic [DEPTH_LOG2-1:0] WAD,
    input  logic [WIDTH-1:0]      DI,
    input  logic [DEPTH_LOG2-1:0] RAD,
    output logic [WIDTH-1:0]      DO
);

    localparam int DEPTH = depth_of(DEPTH_LOG2);

    if (clog2(DEPTH) != DEPTH_LOG2) begin : g_check_geometry
        $error("lutram_sdp: depth %0d inconsistent with DEPTH_LOG2 %0d", DEPTH, DEPTH_LOG2);
    end

    // The storage cells power up as zero, so the initial image is applied by
    // XOR-ing INIT on both write and read: an unwritten word reads back as
    // its INIT value, a written word reads back exactly as written. With the
    // default all-zero INIT the XORs fold away.
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0][WIDTH-1:0] init_words;

    assign init_words = INIT;

    always_ff @(posedge CLK) begin
        if (WRE) begin
            mem[WAD] <= DI ^ init_words[WAD];
        end
    end

    assign DO = mem[RAD] ^ init_words[RAD];

endmodule

// File: rtl/lutram_fifo.sv
// ---------------------------------------------------------------------------
// lutram_fifo
// Parametrised synchronous FIFO on LUT RAM storage, used as a small
// rate-matching buffer. FWFT=1 shows the head word combinationally on DO;
// FWFT=0 registers DO on each accepted read.
//   CLK     in   clock
//   RESETN  in   synchronous active-low reset
//   WRE     in   write request
//   DI      in   write data
//   RDE     in   read request
//   DO      out  read data
//   EMPTY   out  no entries stored
//   FULL    out  depth entries stored
//   AFULL   out  COUNT >= AFULL_LVL
//   COUNT   out  occupancy 0..depth
//   OVF     out  sticky: write attempted while FULL
//   UDF     out  sticky: read attempted while EMPTY
// ---------------------------------------------------------------------------
module lutram_fifo
    import lutram_fifo_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int DEPTH_LOG2 = 4,
    parameter int FWFT       = 1,
    parameter int AFULL_LVL  = 12
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  WRE,
    input  logic [WIDTH-1:0]      DI,
    input  logic                  RDE,
    output logic [WIDTH-1:0]      DO,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  AFULL,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVF,
    output logic                  UDF
);

    localparam int DEPTH = depth_of(DEPTH_LOG2);

    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   AFULL_CNT = AFULL_LVL[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

    `LUTRAM_FIFO_CHECK_PARAMS(WIDTH, DEPTH_LOG2, AFULL_LVL)

    if (FWFT != 0 && FWFT != 1) begin : g_check_fwft
        $error("lutram_fifo: FWFT must be 0 or 1, got %0d", FWFT);
    end

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  empty_q;
    logic                  full_q;
    logic                  afull_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  wr_acc;
    logic                  rd_acc;
    fifo_op_e              op;
    logic [WIDTH-1:0]      ram_do;

    // Acceptance uses only registered flags, so there is no combinational
    // path from the requests to any flag output.
    always_comb begin
        wr_acc     = WRE & ~full_q;
        rd_acc     = RDE & ~empty_q;
        op         = fifo_op_e'({wr_acc, rd_acc});
        count_next = count_q;
        case (op)
            OP_WRITE: count_next = count_q + CNT_ONE;
            OP_READ:  count_next = count_q - CNT_ONE;
            default:  count_next = count_q;
        endcase
    end

    // Flags are registered from the next occupancy so they line up with
    // COUNT on the same edge.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_q <= count_next;
            empty_q <= (count_next == '0);
            full_q  <= (count_next == DEPTH_CNT);
            afull_q <= (count_next >= AFULL_CNT);
            ovf_q   <= ovf_q | (WRE & full_q);
            udf_q   <= udf_q | (RDE & empty_q);
        end
    end

    // Writes in a reset cycle are blocked from reaching the array.
    lutram_sdp #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .CLK (CLK),
        .WRE (wr_acc & RESETN),
        .WAD (wr_ptr),
        .DI  (DI),
        .RAD (rd_ptr),
        .DO  (ram_do)
    );

    if (FWFT != 0) begin : g_fwft
        assign DO = ram_do;
    end else begin : g_reg_read
        logic [WIDTH-1:0] do_q;

        always_ff @(posedge CLK) begin
            if (!RESETN) begin
                do_q <= '0;
            end else if (rd_acc) begin
                do_q <= ram_do;
            end
        end

        assign DO = do_q;
    end

    assign EMPTY = empty_q;
    assign FULL  = full_q;
    assign AFULL = afull_q;
    assign COUNT = count_q;
    assign OVF   = ovf_q;
    assign UDF   = udf_q;

endmodule
